// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
// CNT_W sets the width of the performance counter outputs.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;
    logic             ex_br_taken;
    logic             mem_busy;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_stall;
    logic             exmem_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output ex_br_taken, mem_busy,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
        input  ifid_flush, idex_flush, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  ex_br_taken, mem_busy,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
        output ifid_flush, idex_flush, fwd_a, fwd_b,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: boot flush, memory-wait stall, branch flush,
// load-use bubble and operand forwarding. Define HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_CYC = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int unsigned   BOOT_W    = 4;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic [BOOT_W-1:0] w_boot_cnt_nxt;
    logic              w_load_use;
    logic              w_pc_stall;
    logic              w_ifid_stall;
    logic              w_idex_stall;
    logic              w_exmem_stall;
    logic              w_ifid_flush;
    logic              w_idex_flush;

    // Operand source: MEM result beats WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                        ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
        end
    end

    // Next state and zero-latency stall/flush decode; RUN and WAIT share output rules.
    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_pc_stall     = 1'b0;
        w_ifid_stall   = 1'b0;
        w_idex_stall   = 1'b0;
        w_exmem_stall  = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_pc_stall   = 1'b1;
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_boot_cnt_nxt = '0;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + BOOT_W'(1);
                end
            end
            ST_RUN, ST_WAIT: begin
                if (hz.mem_busy) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_stall  = 1'b1;
                    w_exmem_stall = 1'b1;
                    w_state_nxt   = ST_WAIT;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (hz.ex_br_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_stall   = 1'b1;
                        w_ifid_stall = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_BOOT;
                w_boot_cnt_nxt = '0;
            end
        endcase
    end

    assign hz.pc_stall    = w_pc_stall;
    assign hz.ifid_stall  = w_ifid_stall;
    assign hz.idex_stall  = w_idex_stall;
    assign hz.exmem_stall = w_exmem_stall;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.fwd_a = fwd_sel(hz.ex_rs1, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
    assign hz.fwd_b = fwd_sel(hz.ex_rs2, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters; boot-time stalls/flushes are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state != ST_BOOT) begin
            if (w_pc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`else
    assign hz.stall_cnt = CNT_W'(0);
    assign hz.flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, a negedge
// monitor pops and compares. Counter expectations follow HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;
    localparam int unsigned BOOT_CYC = 4;
    localparam int unsigned CNT_W    = 4;

    typedef struct packed {
        logic [5:0]       ctl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

    pipe_hazard_ctrl #(.BOOT_CYC(BOOT_CYC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    exp_t             q[$];
    int               errors = 0;
    int               checks = 0;
    int               boot_left = BOOT_CYC;
    logic [CNT_W-1:0] m_sc = '0;
    logic [CNT_W-1:0] m_fc = '0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.mem_regwrite && hz.mem_rd != 0 && hz.mem_rd == rs) return 2'b10;
        if (hz.wb_regwrite && hz.wb_rd != 0 && hz.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0; hz.ex_memread = 0;
        hz.mem_rd = 0; hz.mem_regwrite = 0; hz.wb_rd = 0; hz.wb_regwrite = 0;
        hz.ex_br_taken = 0; hz.mem_busy = 0;
    endtask

    task automatic rand_inputs();
        hz.id_rs1       = 5'($urandom_range(0, 3));
        hz.id_rs2       = 5'($urandom_range(0, 3));
        hz.id_use_rs1   = 1'($urandom_range(0, 1));
        hz.id_use_rs2   = 1'($urandom_range(0, 1));
        hz.ex_rs1       = 5'($urandom_range(0, 3));
        hz.ex_rs2       = 5'($urandom_range(0, 3));
        hz.ex_rd        = 5'($urandom_range(0, 3));
        hz.ex_memread   = 1'($urandom_range(0, 1));
        hz.mem_rd       = 5'($urandom_range(0, 3));
        hz.mem_regwrite = 1'($urandom_range(0, 1));
        hz.wb_rd        = 5'($urandom_range(0, 3));
        hz.wb_regwrite  = 1'($urandom_range(0, 1));
        hz.ex_br_taken  = ($urandom_range(0, 5) == 0);
        hz.mem_busy     = ($urandom_range(0, 4) == 0);
    endtask

    // Apply rst level for this cycle and push what the pipeline rules say the outputs must be.
    task automatic push_exp(input logic r);
        exp_t e;
        logic lu;
        logic running;
        rst     = r;
        running = 1'b0;
        lu = hz.ex_memread && hz.ex_rd != 0 &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        e.fa = ref_fwd(hz.ex_rs1);
        e.fb = ref_fwd(hz.ex_rs2);
        if (!r) begin
            boot_left = BOOT_CYC;
            m_sc = '0;
            m_fc = '0;
            e.ctl = 6'b100011;
        end else if (boot_left > 0) begin
            e.ctl = 6'b100011;
            boot_left--;
        end else begin
            running = 1'b1;
            if (hz.mem_busy)         e.ctl = 6'b111100;
            else if (hz.ex_br_taken) e.ctl = 6'b000011;
            else if (lu)             e.ctl = 6'b110001;
            else                     e.ctl = 6'b000000;
        end
`ifdef HAZARD_PERF_EN
        e.sc = m_sc;
        e.fc = m_fc;
`else
        e.sc = '0;
        e.fc = '0;
`endif
        if (running) begin
            if (e.ctl[5] && m_sc != '1) m_sc = m_sc + CNT_W'(1);
            if (e.ctl[1] && m_fc != '1) m_fc = m_fc + CNT_W'(1);
        end
        q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            clear_inputs();
            push_exp(1'b1);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest expectation each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                logic [5:0] ctl;
                e   = q.pop_front();
                ctl = {hz.pc_stall, hz.ifid_stall, hz.idex_stall, hz.exmem_stall,
                       hz.ifid_flush, hz.idex_flush};
                checks++;
                if (ctl !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0t got %b want %b", $time, ctl, e.ctl);
                end
                checks++;
                if ({hz.fwd_a, hz.fwd_b} !== {e.fa, e.fb}) begin
                    errors++;
                    $display("FAIL fwd t=%0t got a=%b b=%b want a=%b b=%b",
                             $time, hz.fwd_a, hz.fwd_b, e.fa, e.fb);
                end
                checks++;
                if ({hz.stall_cnt, hz.flush_cnt} !== {e.sc, e.fc}) begin
                    errors++;
                    $display("FAIL cnt t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             $time, hz.stall_cnt, hz.flush_cnt, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        // Held in reset: boot outputs, forwarding still live.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rand_inputs();
            push_exp(1'b0);
        end
        // Release: exactly BOOT_CYC boot cycles, then quiet.
        idle_cycles(BOOT_CYC + 2);

        // Load-use on rs2, then same with ex_rd = x0.
        next_cycle(); clear_inputs();
        hz.ex_memread = 1; hz.ex_rd = 5; hz.id_rs2 = 5; hz.id_use_rs2 = 1;
        push_exp(1'b1);
        next_cycle(); clear_inputs();
        hz.ex_memread = 1; hz.ex_rd = 0; hz.id_rs2 = 0; hz.id_use_rs2 = 1;
        push_exp(1'b1);

        // Memory busy with a pending branch, then the branch flush.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); clear_inputs();
            hz.mem_busy = 1; hz.ex_br_taken = 1;
            push_exp(1'b1);
        end
        next_cycle(); clear_inputs();
        hz.ex_br_taken = 1;
        push_exp(1'b1);

        // Forwarding priority cases.
        next_cycle(); clear_inputs();
        hz.mem_rd = 7; hz.mem_regwrite = 1; hz.wb_rd = 7; hz.wb_regwrite = 1; hz.ex_rs1 = 7;
        push_exp(1'b1);
        next_cycle();
        hz.mem_regwrite = 0;
        push_exp(1'b1);
        next_cycle(); clear_inputs();
        hz.mem_rd = 0; hz.mem_regwrite = 1; hz.ex_rs2 = 0;
        push_exp(1'b1);

        // Fresh reset, then 5 load-use stalls and 2 taken branches.
        next_cycle(); clear_inputs(); push_exp(1'b0);
        idle_cycles(BOOT_CYC);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); clear_inputs();
            hz.ex_memread = 1; hz.ex_rd = 3; hz.id_rs1 = 3; hz.id_use_rs1 = 1;
            push_exp(1'b1);
            if (i < 2) begin
                next_cycle(); clear_inputs();
                hz.ex_br_taken = 1;
                push_exp(1'b1);
            end
        end
        idle_cycles(2);

        // Random traffic with occasional resets; 4-bit counters reach saturation.
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            rand_inputs();
            push_exp(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
        end
        idle_cycles(1);

        // Enter WAIT, then drop reset mid-cycle: boot outputs and cleared counters before any edge.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); clear_inputs();
            hz.mem_busy = 1;
            push_exp(1'b1);
        end
        next_cycle(); clear_inputs();
        hz.mem_busy = 1;
        push_exp(1'b0);
        next_cycle(); clear_inputs();
        hz.mem_busy = 1;
        push_exp(1'b0);
        idle_cycles(BOOT_CYC + 2);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter BOOT_CYC, default 4: number of post-reset cycles the pipeline is held flushed (range 1..15).
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
REQ-007 ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
REQ-008 ex_rd, ex_memread  in  5, 1  destination and load flag of the instruction in EX.
REQ-009 mem_rd, mem_regwrite  in  5, 1  destination and write-enable of the instruction in MEM.
REQ-010 wb_rd, wb_regwrite  in  5, 1  destination and write-enable of the instruction in WB.
REQ-011 ex_br_taken  in  1  branch/jump resolved taken in EX.
REQ-012 mem_busy  in  1  data memory not ready; the MEM stage cannot complete.
REQ-013 pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the named register.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble (zero) into the named register.
REQ-015 fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 10 MEM result, 01 WB result.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-017 FSM states: BOOT, RUN, WAIT.
REQ-018 In BOOT, the block SHALL drive pc_stall=1, ifid_flush=1, idex_flush=1, and all other stall outputs 0.
REQ-019 A 4-bit boot counter SHALL count BOOT_CYC cycles in BOOT, then the FSM SHALL enter RUN.
REQ-020 In RUN with mem_busy=1, the block SHALL assert all four stall outputs, drive both flushes 0, and enter WAIT on the next edge.
REQ-021 In RUN with mem_busy=0 and ex_br_taken=1, the block SHALL assert ifid_flush=1 and idex_flush=1 with all stalls 0.
- A branch SHALL take priority over load-use in the same cycle.
REQ-022 A load-use hazard SHALL be ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-023 In RUN with mem_busy=0, ex_br_taken=0 and a load-use hazard, the block SHALL assert pc_stall=1, ifid_stall=1 and idex_flush=1 (one bubble); all other outputs 0.
REQ-024 In WAIT with mem_busy=1, all four stalls SHALL be 1 and both flushes 0, regardless of ex_br_taken or load-use.
REQ-025 In WAIT with mem_busy=0, outputs SHALL follow the RUN rules (REQ-021/023) in that same cycle, and the FSM SHALL return to RUN.
REQ-026 Stall/flush outputs SHALL be combinational from the state and current inputs (zero-cycle latency).
REQ-027 fwd_a SHALL be 10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1; otherwise 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1; otherwise 00.
- fwd_b SHALL follow the same rule using ex_rs2.
- The MEM match SHALL win over the WB match.
REQ-028 Forwarding SHALL be combinational and independent of the FSM state.

Reset
REQ-029 rst low SHALL asynchronously force state=BOOT, boot counter=0, stall_cnt=0 and flush_cnt=0.
REQ-030 While rst is low, outputs SHALL equal the BOOT values (REQ-018), with fwd_a and fwd_b determined by the inputs.
REQ-031 Reset asserted mid-WAIT or mid-BOOT SHALL restart the full BOOT sequence after release.

Configuration
REQ-032 Macro HAZARD_PERF_EN: when defined, stall_cnt SHALL increment on every edge where pc_stall=1 outside BOOT.
- flush_cnt SHALL increment on every edge where ifid_flush=1 outside BOOT.
- Both counters SHALL saturate at all-ones.
- When the macro is undefined, both ports SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-033 Release rst with BOOT_CYC=4 -> pc_stall, ifid_flush and idex_flush high for exactly 4 cycles, then all outputs 0.
REQ-034 EX lw x5 (ex_memread=1, ex_rd=5), ID id_rs2=5 with id_use_rs2=1 -> one cycle of pc_stall=1, ifid_stall=1, idex_flush=1.
- Same stimulus with ex_rd=0 -> no stall.
REQ-035 mem_busy high for 3 cycles with ex_br_taken=1 -> all stalls high for 3 cycles with no flush, then one cycle of ifid_flush=1 and idex_flush=1.
REQ-036 mem_rd=7, mem_regwrite=1, wb_rd=7, wb_regwrite=1, ex_rs1=7 -> fwd_a=10.
- Same with mem_regwrite=0 -> fwd_a=01.
- ex_rs2=0 with mem_rd=0 -> fwd_b=00.
REQ-037 With HAZARD_PERF_EN, 5 load-use stalls and 2 taken branches -> stall_cnt=5, flush_cnt=2.
- Without the macro -> both counters read 0.
REQ-038 Assert rst during WAIT -> state returns to BOOT and the counters are cleared immediately, without waiting for a clock edge.
